// File: rtl/apb_master_32bit_if.sv
// rtl/apb_master_32bit_if.sv - host request/response and APB bus bundle for apb_master_32bit
//
// Purpose: groups the host-side request/response handshake and the APB
// master bus into one interface.
// Modports:
//   master - the bridge side: drives req_ready, resp_*, p_addr, p_sel,
//            p_enable, p_write, p_wdata and p_strb; samples the host
//            request, resp_ready and the APB slave return signals.
//   slave  - the environment side (host plus APB slave), mirror image of master.
interface apb_master_32bit_if #(
  parameter int AddrBits = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [AddrBits-1:0] req_addr;
  logic                req_write;
  logic [31:0]         req_wdata;
  logic [3:0]          req_strb;

  logic                resp_valid;
  logic                resp_ready;
  logic [31:0]         resp_rdata;
  logic                resp_err;

  logic [AddrBits-1:0] p_addr;
  logic                p_sel;
  logic                p_enable;
  logic                p_write;
  logic [31:0]         p_wdata;
  logic [3:0]          p_strb;
  logic [31:0]         p_rdata;
  logic                p_ready;
  logic                p_slverr;

  modport master (
    input  req_valid, req_addr, req_write, req_wdata, req_strb,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output p_addr, p_sel, p_enable, p_write, p_wdata, p_strb,
    input  p_rdata, p_ready, p_slverr
  );

  modport slave (
    output req_valid, req_addr, req_write, req_wdata, req_strb,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  p_addr, p_sel, p_enable, p_write, p_wdata, p_strb,
    output p_rdata, p_ready, p_slverr
  );
endinterface

// File: rtl/apb_master_32bit.sv
// rtl/apb_master_32bit.sv - single-outstanding host-request to APB master bridge
//
// Purpose: accepts one host request at a time, runs it as an APB SETUP/ACCESS
// transfer, then holds the response until the host takes it. An ACCESS phase
// that sees no p_ready for TimeoutCycles cycles ends with an error response.
// Ports:
//   p_clk    - clock, all state on rising edge
//   p_resetn - asynchronous active-low reset
//   bus      - apb_master_32bit_if.master: host request/response handshake
//              plus the APB master bus
module apb_master_32bit #(
  parameter int AddrBits      = 32,
  parameter int TimeoutCycles = 16
) (
  input  logic                 p_clk,
  input  logic                 p_resetn,
  apb_master_32bit_if.master   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  // wait_cnt holds the number of ACCESS cycles already spent without
  // p_ready, so the cycle that would be number TimeoutCycles ends the wait.
  localparam logic [7:0] WaitLast = 8'(TimeoutCycles - 1);

  state_t state;
  state_t state_nxt;

  logic [AddrBits-1:0] addr_q;
  logic                write_q;
  logic [31:0]         wdata_q;
  logic [3:0]          strb_q;
  logic [31:0]         rdata_q;
  logic                err_q;
  logic [7:0]          wait_cnt;

  logic accept;
  logic timed_out;

  assign accept    = (state == IDLE) && bus.req_valid;
  assign timed_out = (state == ACCESS) && !bus.p_ready && (wait_cnt == WaitLast);

  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.req_valid) state_nxt = SETUP;
      SETUP:   state_nxt = ACCESS;
      ACCESS:  if (bus.p_ready || timed_out) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
    bus.p_sel      = (state == SETUP) || (state == ACCESS);
    bus.p_enable   = (state == ACCESS);
  end

  // Transfer fields are only loaded on acceptance, so they stay put through
  // SETUP/ACCESS and keep their last values in RESP and IDLE.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      wait_cnt <= '0;
    end else if (accept) begin
      addr_q   <= bus.req_addr;
      write_q  <= bus.req_write;
      wdata_q  <= bus.req_wdata;
      strb_q   <= bus.req_write ? bus.req_strb : 4'b0000;
      wait_cnt <= '0;
    end else if (state == ACCESS) begin
      if (bus.p_ready) begin
        rdata_q <= write_q ? 32'h0 : bus.p_rdata;
        err_q   <= bus.p_slverr;
      end else if (timed_out) begin
        rdata_q <= 32'h0;
        err_q   <= 1'b1;
      end else if (wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

  assign bus.p_addr     = addr_q;
  assign bus.p_write    = write_q;
  assign bus.p_wdata    = wdata_q;
  assign bus.p_strb     = strb_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_apb_master_32bit.sv
// tb/tb_apb_master_32bit.sv - self-checking bench for apb_master_32bit
module tb_apb_master_32bit;
  localparam int AW = 32;
  localparam int TO = 16;

  logic p_clk    = 1'b0;
  logic p_resetn = 1'b0;

  apb_master_32bit_if #(.AddrBits(AW)) bus ();

  apb_master_32bit #(
    .AddrBits(AW),
    .TimeoutCycles(TO)
  ) dut (
    .p_clk(p_clk),
    .p_resetn(p_resetn),
    .bus(bus)
  );

  always #5 p_clk = ~p_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference behaviour: a transfer whose slave inserts `waits` wait states
  // occupies waits+1 ACCESS cycles unless that reaches the timeout, in which
  // case it occupies exactly TO cycles and returns an error with zero data.
  task automatic run_txn(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input logic slverr,
                         input logic [31:0] rdata, input int resp_delay, input bit hold_valid);
    int          exp_acc;
    logic        exp_err;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    int          acc;
    int          cyc;
    bit          seen;
    bit          stable;
    bit          held;
    exp_acc   = (waits >= TO) ? TO : waits + 1;
    exp_err   = (waits >= TO) ? 1'b1 : slverr;
    exp_rdata = (waits >= TO || wr) ? 32'h0 : rdata;
    exp_strb  = wr ? strb : 4'b0000;
    acc = 0; cyc = 0; seen = 0; stable = 1; held = 1;

    check("idle_req_ready", 64'(bus.req_ready), 64'(1));
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_write = wr;
    bus.req_wdata = wdata;
    bus.req_strb  = strb;
    @(posedge p_clk);
    @(negedge p_clk);
    if (hold_valid) begin
      bus.req_addr  = $urandom;
      bus.req_write = ~wr;
      bus.req_wdata = $urandom;
      bus.req_strb  = 4'($urandom);
    end else begin
      bus.req_valid = 1'b0;
    end
    check("setup_sel_en", 64'({bus.p_sel, bus.p_enable}), 64'(2'b10));
    check("setup_addr", 64'(bus.p_addr), 64'(addr));
    check("setup_write", 64'(bus.p_write), 64'(wr));
    check("setup_wdata", 64'(bus.p_wdata), 64'(wdata));
    check("setup_strb", 64'(bus.p_strb), 64'(exp_strb));
    check("setup_req_ready", 64'(bus.req_ready), 64'(0));
    bus.p_rdata  = rdata;
    bus.p_slverr = slverr;
    bus.p_ready  = 1'($urandom);

    while (!seen && cyc < 60) begin
      @(negedge p_clk);
      cyc++;
      if (bus.resp_valid) begin
        seen = 1;
      end else begin
        if (bus.p_sel && bus.p_enable) begin
          acc++;
          bus.p_ready = (acc == waits + 1);
        end
        if (bus.p_addr != addr || bus.p_write != wr || bus.p_wdata != wdata ||
            bus.p_strb != exp_strb || bus.req_ready) stable = 0;
      end
    end
    bus.p_ready  = 1'($urandom);
    bus.p_slverr = 1'($urandom);
    bus.p_rdata  = $urandom;

    check("resp_seen", 64'(seen), 64'(1));
    check("access_cycles", 64'(acc), 64'(exp_acc));
    check("resp_latency", 64'(cyc), 64'(exp_acc + 1));
    check("bus_stable", 64'(stable), 64'(1));
    check("resp_rdata", 64'(bus.resp_rdata), 64'(exp_rdata));
    check("resp_err", 64'(bus.resp_err), 64'(exp_err));
    check("resp_sel_en", 64'({bus.p_sel, bus.p_enable}), 64'(0));

    for (int i = 0; i < resp_delay; i++) begin
      @(negedge p_clk);
      bus.p_ready  = 1'($urandom);
      bus.p_slverr = 1'($urandom);
      if (!bus.resp_valid || bus.resp_rdata != exp_rdata || bus.resp_err != exp_err ||
          bus.req_ready || bus.p_sel || bus.p_addr != addr) held = 0;
    end
    check("resp_held", 64'(held), 64'(1));

    bus.resp_ready = 1'b1;
    @(negedge p_clk);
    bus.resp_ready = 1'b0;
    check("back_idle", 64'({bus.resp_valid, bus.req_ready, bus.p_sel}), 64'(3'b010));
    check("idle_addr_hold", 64'(bus.p_addr), 64'(addr));
  endtask

  initial begin
    int          waits;
    logic        wr;
    bit          no_resp;
    bus.req_valid  = 1'b0;
    bus.req_addr   = '0;
    bus.req_write  = 1'b0;
    bus.req_wdata  = '0;
    bus.req_strb   = '0;
    bus.resp_ready = 1'b0;
    bus.p_rdata    = '0;
    bus.p_ready    = 1'b0;
    bus.p_slverr   = 1'b0;

    repeat (3) @(negedge p_clk);
    check("rst_ready_valid", 64'({bus.req_ready, bus.resp_valid, bus.resp_err}), 64'(3'b100));
    check("rst_sel_en_wr", 64'({bus.p_sel, bus.p_enable, bus.p_write}), 64'(0));
    check("rst_data", 64'({bus.p_addr, bus.p_wdata}), 64'(0));
    check("rst_strb_rdata", 64'({bus.p_strb, bus.resp_rdata}), 64'(0));
    p_resetn = 1'b1;
    @(negedge p_clk);

    // zero-wait write, 3-wait read, slave error, timeout
    run_txn(32'h10, 1'b1, 32'hDEADBEEF, 4'b0011, 0, 1'b0, 32'h12345678, 0, 0);
    run_txn(32'h10, 1'b0, 32'hCAFEF00D, 4'b1111, 3, 1'b0, 32'h0000BEEF, 0, 0);
    run_txn(32'h400, 1'b0, 32'h0, 4'b0000, 0, 1'b1, 32'hA5A5A5A5, 1, 0);
    run_txn(32'h20, 1'b1, 32'h11112222, 4'b1010, 40, 1'b0, 32'h0, 0, 0);
    // backpressure with req_valid held high across back-to-back requests
    run_txn(32'h30, 1'b1, 32'h0BADF00D, 4'b1100, 1, 1'b0, 32'h0, 5, 1);
    run_txn(32'h34, 1'b0, 32'h0, 4'b0101, 2, 1'b0, 32'h87654321, 5, 1);
    bus.req_valid = 1'b0;

    for (int t = 0; t < 30; t++) begin
      waits = ($urandom_range(0, 7) == 0) ? $urandom_range(TO - 1, TO + 4) : $urandom_range(0, 6);
      wr    = 1'($urandom);
      run_txn({$urandom} & 32'hFFFF_FFFC, wr, $urandom, 4'($urandom), waits,
              ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 4), 0);
    end

    // reset during ACCESS drops the transfer
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h88;
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h5555AAAA;
    bus.req_strb  = 4'hF;
    @(posedge p_clk);
    @(negedge p_clk);
    bus.req_valid = 1'b0;
    bus.p_ready   = 1'b0;
    @(negedge p_clk);
    check("pre_rst_access", 64'({bus.p_sel, bus.p_enable}), 64'(2'b11));
    p_resetn = 1'b0;
    #1;
    check("async_rst_sel_en", 64'({bus.p_sel, bus.p_enable}), 64'(0));
    check("async_rst_ready", 64'({bus.req_ready, bus.resp_valid}), 64'(2'b10));
    check("async_rst_bus", 64'({bus.p_addr, bus.p_wdata}), 64'(0));
    repeat (2) @(negedge p_clk);
    p_resetn = 1'b1;
    no_resp = 1;
    repeat (3) begin
      @(negedge p_clk);
      if (bus.resp_valid || !bus.req_ready) no_resp = 0;
    end
    check("no_resp_after_rst", 64'(no_resp), 64'(1));
    run_txn(32'h90, 1'b0, 32'h0, 4'b1111, 0, 1'b0, 32'h600DCAFE, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/apb_master_32bit.md
APB_MASTER_32BIT -- requirements
Module: apb_master_32bit

Interface
REQ-001 The block SHALL have parameter AddrBits, default 32, giving the APB address width.
REQ-002 The block SHALL have parameter TimeoutCycles, default 16, giving the maximum number of ACCESS cycles to wait for p_ready (legal range 2..255).
REQ-003 The block SHALL use one clock and an asynchronous active-low reset; ports SHALL be as follows:
- p_clk  in  1  clock, all state on rising edge
- p_resetn  in  1  asynchronous active-low reset
- req_valid  in  1  host request valid
- req_ready  out  1  block can accept a request
- req_addr  in  AddrBits  request byte address
- req_write  in  1  1 = write, 0 = read
- req_wdata  in  32  write data
- req_strb  in  4  write byte strobes
- resp_valid  out  1  response valid
- resp_ready  in  1  host accepts the response
- resp_rdata  out  32  read data (0 for writes and timeouts)
- resp_err  out  1  slave error or timeout
- p_addr  out  AddrBits  APB address
- p_sel  out  1  APB select
- p_enable  out  1  APB enable
- p_write  out  1  APB direction
- p_wdata  out  32  APB write data
- p_strb  out  4  APB strobes
- p_rdata  in  32  APB read data
- p_ready  in  1  APB ready
- p_slverr  in  1  APB slave error

Function
REQ-004 The block SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP, with all outputs registered or decoded from state only.
REQ-005 req_ready SHALL be 1 only in IDLE; a request SHALL be accepted on the edge where req_valid=1 and req_ready=1, and all req_* fields SHALL be captured on that edge.
REQ-006 Acceptance SHALL move IDLE->SETUP; SETUP SHALL drive p_sel=1, p_enable=0, and present captured p_addr, p_write, p_wdata and p_strb.
REQ-007 SETUP SHALL move unconditionally to ACCESS after one cycle; ACCESS SHALL drive p_sel=1, p_enable=1.
REQ-008 p_addr, p_write, p_wdata and p_strb SHALL remain stable from SETUP entry until ACCESS exit.
REQ-009 For reads, p_strb SHALL be 4'b0000 regardless of req_strb.
REQ-010 In ACCESS with p_ready=1, the block SHALL perform these actions and move to RESP: capture resp_rdata=p_rdata for reads (0 for writes) and resp_err=p_slverr.
REQ-011 A wait counter SHALL count ACCESS cycles with p_ready=0; when TimeoutCycles ACCESS cycles have elapsed without p_ready, the block SHALL move to RESP with resp_err=1 and resp_rdata=0, and p_ready/p_slverr SHALL be ignored thereafter.
REQ-012 The wait counter SHALL clear on SETUP entry and SHALL NOT wrap.
REQ-013 RESP SHALL assert resp_valid=1 with resp_rdata/resp_err stable until resp_ready=1, then move to IDLE; p_sel=p_enable=0 in RESP and IDLE.
REQ-014 With a zero-wait slave, the response latency SHALL be as follows: acceptance at edge N, SETUP in cycle N..N+1, ACCESS N+1..N+2, resp_valid from N+2; minimum throughput SHALL be one transfer per 4 cycles.
REQ-015 req_valid arriving outside IDLE SHALL be held off (req_ready=0) and SHALL NOT corrupt the in-flight transfer.
REQ-016 In IDLE and RESP, p_addr, p_write, p_wdata and p_strb SHALL hold their last values.

Reset
REQ-017 While p_resetn=0, the block SHALL immediately force the following: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; p_sel=0; p_enable=0; p_write=0; p_addr=0; p_wdata=0; p_strb=0; wait counter=0.
REQ-018 Reset asserted mid-transfer SHALL drop the transfer with no response; after release, the first edge SHALL be able to accept a new request.

Verification
REQ-019 Write with zero-wait slave: req addr=0x10, wdata=0xDEADBEEF, strb=4'b0011 -> p_sel then p_enable on consecutive cycles, p_strb=0011, resp_valid at N+2 with resp_err=0, resp_rdata=0.
REQ-020 Read with 3 wait states: addr=0x10, p_ready low for 3 ACCESS cycles, then p_rdata=0x0000BEEF -> p_strb=0, ACCESS lasts 4 cycles, resp_rdata=0x0000BEEF, resp_err=0.
REQ-021 Slave error: p_ready=1 with p_slverr=1 on addr=0x400 -> resp_err=1, returning to IDLE after resp_ready.
REQ-022 Timeout: p_ready held 0 -> exactly 16 ACCESS cycles, then p_sel=0 and resp_valid=1, with resp_err=1 and resp_rdata=0.
REQ-023 Backpressure with back-to-back requests: resp_ready low for 5 cycles, req_valid held high -> resp stable, req_ready=0 throughout, second transfer starts only after resp handshake.
REQ-024 Reset mid-operation: assert p_resetn=0 during ACCESS -> p_sel=p_enable=0 asynchronously, no resp_valid after release.
